// File: rtl/sprite_pixel_streamer.sv
// Walks a sprite held linearly in synchronous memory and streams its pixels row-major
// on a valid/ready interface, with colour-key draw flags and a 2-entry latency buffer.
module sprite_pixel_streamer #(
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] sprite_base,
  input  logic [10:0]       dest_x_in,
  input  logic [10:0]       dest_y_in,
  input  logic [10:0]       width,
  input  logic [10:0]       height,
  input  logic              key_enable,
  input  logic [7:0]        key_color,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [10:0]       pixel_x,
  output logic [10:0]       pixel_y,
  output logic [7:0]        pixel_data,
  output logic              pixel_valid,
  output logic              draw,
  output logic              pixel_last,
  input  logic              pixel_ready,
  output logic              busy,
  output logic              done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_t;

  state_t              r_state;
  state_t              w_nextState;

  logic [ADDR_W-1:0]   r_base;
  logic [ADDR_W-1:0]   r_index;
  logic [10:0]         r_destX;
  logic [10:0]         r_destY;
  logic [10:0]         r_width;
  logic [10:0]         r_height;
  logic [10:0]         r_col;
  logic [10:0]         r_row;
  logic                r_keyEn;
  logic [7:0]          r_keyColor;

  logic                r_inflight;
  logic                r_inflightLast;

  logic [7:0]          r_fifoData [FIFO_DEPTH];
  logic                r_fifoLast [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_rdPtr;
  logic [PTR_W-1:0]    r_wrPtr;
  logic [1:0]          r_count;

  logic                w_pop;
  logic                w_issue;
  logic                w_lastIssue;
  logic                w_done;
  logic                w_accept;

  assign pixel_valid = (r_count != 2'd0);
  assign w_pop       = pixel_valid & pixel_ready;

  // Reads already in flight or buffered must never exceed the buffer, counting this cycle's pop.
  assign w_issue     = (r_state == FETCH) &&
                       (({1'b0, r_count} + {2'b0, r_inflight}) < (3'(FIFO_DEPTH) + {2'b0, w_pop}));
  assign w_lastIssue = w_issue && (r_col == r_width) && (r_row == r_height);
  assign w_done      = (r_state == DRAIN) && (r_count == 2'd0) && !r_inflight;
  assign busy        = (r_state != IDLE) && !w_done;
  assign w_accept    = start && !busy;
  assign done        = w_done;

  assign mem_en      = w_issue;
  assign mem_addr    = r_base + r_index;
  assign pixel_x     = r_destX;
  assign pixel_y     = r_destY;
  assign pixel_data  = r_fifoData[r_rdPtr];
  assign pixel_last  = pixel_valid && r_fifoLast[r_rdPtr];
  assign draw        = pixel_valid && !(r_keyEn && (pixel_data == r_keyColor));

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = FETCH;
      FETCH:   if (w_lastIssue) w_nextState = DRAIN;
      DRAIN:   if (w_done) w_nextState = w_accept ? FETCH : IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_base     <= '0;
      r_index    <= '0;
      r_destX    <= '0;
      r_destY    <= '0;
      r_width    <= '0;
      r_height   <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_keyEn    <= 1'b0;
      r_keyColor <= '0;
    end else if (w_accept) begin
      r_base     <= sprite_base;
      r_index    <= '0;
      r_destX    <= dest_x_in;
      r_destY    <= dest_y_in;
      r_width    <= width;
      r_height   <= height;
      r_col      <= '0;
      r_row      <= '0;
      r_keyEn    <= key_enable;
      r_keyColor <= key_color;
    end else if (w_issue) begin
      r_index <= r_index + ADDR_W'(1);
      if (r_col == r_width) begin
        r_col <= '0;
        r_row <= r_row + 11'd1;
      end else begin
        r_col <= r_col + 11'd1;
      end
    end
  end

  // Read data lands one cycle after issue and is pushed with its last tag in that cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_inflight     <= 1'b0;
      r_inflightLast <= 1'b0;
      r_rdPtr        <= '0;
      r_wrPtr        <= '0;
      r_count        <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifoData[i] <= '0;
        r_fifoLast[i] <= 1'b0;
      end
    end else begin
      r_inflight     <= w_issue;
      r_inflightLast <= w_lastIssue;
      if (r_inflight) begin
        r_fifoData[r_wrPtr] <= mem_rdata;
        r_fifoLast[r_wrPtr] <= r_inflightLast;
        r_wrPtr             <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

endmodule

// File: tb/tb_sprite_pixel_streamer.sv
// Directed bench for sprite_pixel_streamer: sync memory model, stream monitor and
// hand-computed expectations for each sprite command.
module tb_sprite_pixel_streamer;

  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] sprite_base;
  logic [10:0]       dest_x_in;
  logic [10:0]       dest_y_in;
  logic [10:0]       width;
  logic [10:0]       height;
  logic              key_enable;
  logic [7:0]        key_color;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic [10:0]       pixel_x;
  logic [10:0]       pixel_y;
  logic [7:0]        pixel_data;
  logic              pixel_valid;
  logic              draw;
  logic              pixel_last;
  logic              pixel_ready;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  sprite_pixel_streamer #(.ADDR_W(ADDR_W), .FIFO_DEPTH(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .sprite_base (sprite_base),
    .dest_x_in   (dest_x_in),
    .dest_y_in   (dest_y_in),
    .width       (width),
    .height      (height),
    .key_enable  (key_enable),
    .key_color   (key_color),
    .mem_en      (mem_en),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .pixel_data  (pixel_data),
    .pixel_valid (pixel_valid),
    .draw        (draw),
    .pixel_last  (pixel_last),
    .pixel_ready (pixel_ready),
    .busy        (busy),
    .done        (done)
  );

  // Synchronous sprite memory with one cycle of read latency
  logic [7:0] mem [0:65535];
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= mem[mem_addr];
  end

  function automatic logic [7:0] fillVal(input int a);
    return 8'((a * 7 + 3) & 255);
  endfunction

  int checks = 0;
  int failures = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Stream monitor, sampled on the falling edge
  int          cyc = 0;
  int          startCyc = 0;
  int          doneCnt = 0;
  int          doneCyc = 0;
  int          stallErr = 0;
  int          outstanding = 0;
  int          maxOut = 0;
  logic [15:0] addrQ [$];
  int          issueCycQ [$];
  logic [7:0]  dataQ [$];
  logic        drawQ [$];
  logic        lastQ [$];
  int          pixCycQ [$];
  logic        prevStall = 1'b0;
  logic [7:0]  prevData;
  logic        prevDraw;
  logic        prevLast;

  always @(negedge clk) begin
    cyc++;
    if (done) begin
      doneCnt++;
      doneCyc = cyc;
    end
    if (!reset) begin
      prevStall   = 1'b0;
      outstanding = 0;
    end else begin
      if (start && !busy) startCyc = cyc;
      if (mem_en) begin
        addrQ.push_back(mem_addr);
        issueCycQ.push_back(cyc);
        outstanding++;
      end
      if (prevStall && (!pixel_valid || pixel_data !== prevData ||
                        draw !== prevDraw || pixel_last !== prevLast)) stallErr++;
      if (pixel_valid && pixel_ready) begin
        dataQ.push_back(pixel_data);
        drawQ.push_back(draw);
        lastQ.push_back(pixel_last);
        pixCycQ.push_back(cyc);
        outstanding--;
      end
      if (outstanding > maxOut) maxOut = outstanding;
      prevStall = pixel_valid && !pixel_ready;
      prevData  = pixel_data;
      prevDraw  = draw;
      prevLast  = pixel_last;
    end
  end

  task automatic clearLog();
    addrQ.delete();
    issueCycQ.delete();
    dataQ.delete();
    drawQ.delete();
    lastQ.delete();
    pixCycQ.delete();
    stallErr = 0;
    maxOut   = 0;
  endtask

  task automatic applyStimulus(input logic [15:0] base, input logic [10:0] w, input logic [10:0] h,
                               input logic [10:0] dx, input logic [10:0] dy,
                               input logic ke, input logic [7:0] kc);
    @(posedge clk); #1;
    sprite_base = base;
    width       = w;
    height      = h;
    dest_x_in   = dx;
    dest_y_in   = dy;
    key_enable  = ke;
    key_color   = kc;
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // readyMode 0: ready held high; 1: ready follows 1,0,0,1 repeating. pulseAt injects a start.
  task automatic runUntilDone(input int budget, input int readyMode, input int pulseAt);
    int startDone = doneCnt;
    int n = 0;
    while (doneCnt == startDone && n < budget) begin
      pixel_ready = (readyMode == 0) ? 1'b1 : ((n % 4 == 0) || (n % 4 == 3));
      start = (n == pulseAt);
      if (n == pulseAt) begin
        sprite_base = 16'h7000;
        dest_x_in   = 11'd999;
        dest_y_in   = 11'd888;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    checkOutput("done_timeout", 32'(doneCnt != startDone), 32'd1);
    @(negedge clk);
  endtask

  task automatic checkPixels(input string tag, input logic [15:0] base, input int n);
    int err = 0;
    checkOutput({tag, "_count"}, dataQ.size(), n);
    for (int i = 0; i < dataQ.size() && i < n; i++) begin
      if (dataQ[i] !== mem[base + 16'(i)]) err++;
    end
    checkOutput({tag, "_dataErr"}, err, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp1 [4];
    logic [7:0] exp3 [4];
    int         savedDone;
    int         t;
    int         lastCnt;

    for (int i = 0; i < 65536; i++) mem[i] = fillVal(i);
    exp1 = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp3 = '{8'h00, 8'h7F, 8'h00, 8'hFF};
    for (int i = 0; i < 4; i++) begin
      mem[16'h0100 + 16'(i)] = exp1[i];
      mem[16'h0200 + 16'(i)] = exp3[i];
    end
    mem[16'h0180] = 8'hA1;
    mem[16'h0181] = 8'hB2;
    mem[16'h0182] = 8'hC3;
    mem[16'h0183] = 8'hD4;

    reset = 1'b0;
    start = 1'b0;
    sprite_base = '0;
    dest_x_in = '0;
    dest_y_in = '0;
    width = '0;
    height = '0;
    key_enable = 1'b0;
    key_color = '0;
    pixel_ready = 1'b1;

    $display("[TB] reset values");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_mem_en", mem_en, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_valid", pixel_valid, 0);
    checkOutput("rst_data", pixel_data, 0);
    checkOutput("rst_draw", draw, 0);
    checkOutput("rst_last", pixel_last, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_xy", {pixel_x, pixel_y}, 0);
    reset = 1'b1;

    $display("[TB] test 1: 4x1 sprite, continuous ready");
    clearLog();
    applyStimulus(16'h0100, 11'd3, 11'd0, 11'd40, 11'd20, 1'b0, 8'h00);
    runUntilDone(50, 0, -1);
    checkOutput("t1_nIssue", addrQ.size(), 4);
    for (int i = 0; i < addrQ.size() && i < 4; i++)
      checkOutput("t1_addr", addrQ[i], 16'h0100 + 16'(i));
    checkOutput("t1_nPix", dataQ.size(), 4);
    for (int i = 0; i < dataQ.size() && i < 4; i++) begin
      checkOutput("t1_data", dataQ[i], exp1[i]);
      checkOutput("t1_last", lastQ[i], (i == 3));
    end
    if (issueCycQ.size() == 4 && pixCycQ.size() == 4) begin
      checkOutput("t1_issueLatency", issueCycQ[0] - startCyc, 1);
      checkOutput("t1_issueSpan", issueCycQ[3] - issueCycQ[0], 3);
      checkOutput("t1_pixLatency", pixCycQ[0] - startCyc, 3);
      checkOutput("t1_pixSpan", pixCycQ[3] - pixCycQ[0], 3);
      checkOutput("t1_doneCyc", doneCyc - pixCycQ[3], 1);
    end
    checkOutput("t1_pixel_x", pixel_x, 11'd40);
    checkOutput("t1_pixel_y", pixel_y, 11'd20);
    checkOutput("t1_busyAfter", busy, 0);

    $display("[TB] test 2: 2x2 sprite, toggling ready");
    clearLog();
    applyStimulus(16'h0180, 11'd1, 11'd1, 11'd5, 11'd6, 1'b0, 8'h00);
    runUntilDone(100, 1, -1);
    checkPixels("t2", 16'h0180, 4);
    checkOutput("t2_stallErr", stallErr, 0);
    checkOutput("t2_maxOutstanding", 32'(maxOut <= 2), 1);
    pixel_ready = 1'b1;

    $display("[TB] test 3: colour key");
    clearLog();
    applyStimulus(16'h0200, 11'd3, 11'd0, 11'd0, 11'd0, 1'b1, 8'h00);
    runUntilDone(50, 0, -1);
    checkOutput("t3_nPixKey", drawQ.size(), 4);
    for (int i = 0; i < drawQ.size() && i < 4; i++)
      checkOutput("t3_drawKey", drawQ[i], (i % 2 == 1));
    clearLog();
    applyStimulus(16'h0200, 11'd3, 11'd0, 11'd0, 11'd0, 1'b0, 8'h00);
    runUntilDone(50, 0, -1);
    checkOutput("t3_nPixNoKey", drawQ.size(), 4);
    for (int i = 0; i < drawQ.size() && i < 4; i++)
      checkOutput("t3_drawNoKey", drawQ[i], 1);

    $display("[TB] test 4: 17x2 sprite with ignored start");
    clearLog();
    savedDone = doneCnt;
    applyStimulus(16'h0300, 11'd16, 11'd1, 11'd100, 11'd50, 1'b0, 8'h00);
    runUntilDone(200, 0, 10);
    checkPixels("t4", 16'h0300, 34);
    lastCnt = 0;
    foreach (lastQ[i]) if (lastQ[i]) lastCnt++;
    checkOutput("t4_lastCount", lastCnt, 1);
    if (lastQ.size() == 34) checkOutput("t4_lastPos", lastQ[33], 1);
    if (pixCycQ.size() == 34) checkOutput("t4_pixSpan", pixCycQ[33] - pixCycQ[0], 33);
    checkOutput("t4_doneCount", doneCnt - savedDone, 1);
    checkOutput("t4_pixel_x", pixel_x, 11'd100);
    checkOutput("t4_pixel_y", pixel_y, 11'd50);

    $display("[TB] test 5: reset mid-operation");
    clearLog();
    applyStimulus(16'h0400, 11'd7, 11'd7, 11'd300, 11'd200, 1'b0, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    savedDone = doneCnt;
    reset = 1'b0;
    #2;
    checkOutput("t5_mem_en", mem_en, 0);
    checkOutput("t5_valid", pixel_valid, 0);
    checkOutput("t5_data", pixel_data, 0);
    checkOutput("t5_last", pixel_last, 0);
    checkOutput("t5_draw", draw, 0);
    checkOutput("t5_busy", busy, 0);
    checkOutput("t5_xy", {pixel_x, pixel_y}, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("t5_noDone", doneCnt - savedDone, 0);
    checkOutput("t5_idleValid", pixel_valid, 0);
    clearLog();
    applyStimulus(16'h0500, 11'd3, 11'd0, 11'd1, 11'd2, 1'b0, 8'h00);
    runUntilDone(50, 0, -1);
    if (addrQ.size() > 0) checkOutput("t5_firstAddr", addrQ[0], 16'h0500);
    checkPixels("t5", 16'h0500, 4);
    checkOutput("t5_doneCount", doneCnt - savedDone, 1);

    $display("[TB] test 6: single pixel, delayed ready");
    clearLog();
    pixel_ready = 1'b0;
    applyStimulus(16'h0600, 11'd0, 11'd0, 11'd7, 11'd8, 1'b0, 8'h00);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("t6_heldValid", pixel_valid, 1);
    checkOutput("t6_heldLast", pixel_last, 1);
    checkOutput("t6_heldData", pixel_data, fillVal(16'h0600));
    checkOutput("t6_noPopYet", dataQ.size(), 0);
    t = cyc;
    runUntilDone(20, 0, -1);
    checkOutput("t6_nPix", dataQ.size(), 1);
    checkOutput("t6_stallErr", stallErr, 0);
    if (pixCycQ.size() == 1) begin
      checkOutput("t6_acceptCyc", pixCycQ[0] - t, 1);
      checkOutput("t6_doneCyc", doneCyc - pixCycQ[0], 1);
      checkOutput("t6_lastFlag", lastQ[0], 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
